// File: rtl/dm_port_arbiter_if.sv
// Signal bundle around the data-memory port arbiter: pipeline request, host burst port, memory side.
// The arbiter uses the slave modport; the requester/memory side uses master.
interface dm_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_en;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;

  logic              host_req;
  logic              host_rw;
  logic [ADDR_W-1:0] host_addr;
  logic [3:0]        host_len;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              host_done;

  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_en, cpu_rw, cpu_addr, cpu_wdata,
    input  host_req, host_rw, host_addr, host_len, host_wdata,
    input  mem_rdata,
    output cpu_stall,
    output host_gnt, host_ack, host_rvalid, host_rdata, host_done,
    output mem_en, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output cpu_en, cpu_rw, cpu_addr, cpu_wdata,
    output host_req, host_rw, host_addr, host_len, host_wdata,
    output mem_rdata,
    input  cpu_stall,
    input  host_gnt, host_ack, host_rvalid, host_rdata, host_done,
    input  mem_en, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Shares the data-memory port between the pipeline (default priority) and host bursts with anti-starvation.
// Optional macro DM_ARB_PERF_EN adds o_stall_cnt, a saturating count of cpu_stall cycles.
module dm_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  dm_port_arbiter_if.slave    bus
`ifdef DM_ARB_PERF_EN
  ,
  output logic [15:0]         o_stall_cnt
`endif
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOST = 1'b1;

  logic [0:0]        r_state;
  logic              r_rw;
  logic [ADDR_W-1:0] r_base;
  logic [BW-1:0]     r_beats_left;
  logic [BW-1:0]     r_idx;
  logic [SW-1:0]     r_starve;
  logic              r_rvalid;
  logic              r_done;

  logic              w_host_win;
  logic              w_last;
  logic              w_cpu_stall;
  logic [BW-1:0]     w_len;

  assign w_host_win  = (r_state == IDLE) && bus.host_req &&
                       (!bus.cpu_en || (r_starve == SW'(STARVE_LIMIT)));
  assign w_last      = (r_state == HOST) && (r_beats_left == BW'(1));
  assign w_cpu_stall = i_rst_n && (r_state == HOST) && bus.cpu_en;

  // A zero length still moves one beat; oversize requests are cut to one full burst.
  always_comb begin
    w_len = BW'(bus.host_len);
    if (bus.host_len == 4'd0)
      w_len = BW'(1);
    else if (int'(bus.host_len) > MAX_BURST)
      w_len = BW'(MAX_BURST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_rw         <= 1'b0;
      r_base       <= '0;
      r_beats_left <= '0;
      r_idx        <= '0;
    end else if (r_state == IDLE) begin
      if (w_host_win) begin
        r_state      <= HOST;
        r_rw         <= bus.host_rw;
        r_base       <= bus.host_addr;
        r_beats_left <= w_len;
        r_idx        <= '0;
      end
    end else begin
      r_beats_left <= r_beats_left - BW'(1);
      r_idx        <= r_idx + BW'(1);
      if (w_last)
        r_state <= IDLE;
    end
  end

  // Counts how long a pending host request has been refused because the pipeline kept the port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve <= '0;
    end else if (r_state == IDLE) begin
      if (w_host_win || !bus.host_req)
        r_starve <= '0;
      else if (bus.cpu_en && (r_starve != SW'(STARVE_LIMIT)))
        r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rvalid <= (r_state == HOST) && !r_rw;
      r_done   <= w_last;
    end
  end

  // Outputs are forced low while reset is held so a burst in flight is cut off immediately.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.host_gnt  = 1'b0;
    bus.host_ack  = 1'b0;
    if (i_rst_n) begin
      if (r_state == HOST) begin
        bus.mem_en    = 1'b1;
        bus.mem_rw    = r_rw;
        bus.mem_addr  = r_base + ADDR_W'(r_idx);
        bus.mem_wdata = bus.host_wdata;
        bus.host_gnt  = 1'b1;
        bus.host_ack  = 1'b1;
      end else begin
        bus.mem_en    = bus.cpu_en;
        bus.mem_rw    = bus.cpu_rw;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
    end
  end

  assign bus.cpu_stall   = w_cpu_stall;
  assign bus.host_rvalid = r_rvalid;
  assign bus.host_rdata  = r_rvalid ? bus.mem_rdata : '0;
  assign bus.host_done   = r_done;

`ifdef DM_ARB_PERF_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_stall_cnt <= '0;
    else if (w_cpu_stall && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: a transaction-level model queues per-cycle expectations,
// a monitor pops and compares them. Define DM_ARB_PERF_EN to also check the stall counter.
module tb_dm_port_arbiter;

  localparam int STARVE_LIMIT = 4;
  localparam int MAX_BURST    = 8;

  typedef struct packed {
    logic        rstN;
    logic        cpuEn;
    logic        cpuRw;
    logic [15:0] cpuAddr;
    logic [15:0] cpuWdata;
    logic        hostReq;
    logic        hostRw;
    logic [15:0] hostAddr;
    logic [3:0]  hostLen;
    logic [15:0] hostWdata;
  } stimT;

  typedef struct packed {
    logic        memEn;
    logic        memRw;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
    logic        stall;
    logic        gnt;
    logic        ack;
    logic        rvalid;
    logic [15:0] rdata;
    logic        done;
    logic [15:0] stallCnt;
  } expT;

  logic clk;
  logic rst_n;
  logic [15:0] stallCnt;

  dm_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dm_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MAX_BURST(MAX_BURST), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
`ifdef DM_ARB_PERF_EN
    ,
    .o_stall_cnt (stallCnt)
`endif
  );

`ifndef DM_ARB_PERF_EN
  assign stallCnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory behind the port: one-cycle read latency, write on the clock edge.
  logic [15:0] dutMem [0:65535];
  logic [15:0] refMem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_rw) dutMem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= dutMem[bus.mem_addr];
    end
  end

  expT         expQ[$];
  logic [15:0] hostBeats[$];
  logic        burstRw;
  int          starve;
  logic        pendRvalid;
  logic [15:0] pendRdata;
  logic        pendDone;
  int          modelStalls;
  int          checks;
  int          errors;

  // Reference: a granted burst is just a list of addresses the port will serve, one per cycle.
  task automatic runModel(input stimT s);
    expT e;
    logic [15:0] beat;
    int n;
    e = '0;
    if (!s.rstN) begin
      hostBeats.delete();
      starve = 0; pendRvalid = 0; pendDone = 0; modelStalls = 0;
      expQ.push_back(e);
      return;
    end
    e.rvalid   = pendRvalid;
    e.rdata    = pendRvalid ? pendRdata : 16'h0;
    e.done     = pendDone;
    e.stallCnt = 16'(modelStalls);
    pendRvalid = 0;
    pendDone   = 0;
    if (hostBeats.size() > 0) begin
      beat       = hostBeats.pop_front();
      e.memEn    = 1; e.memRw = burstRw; e.memAddr = beat; e.memWdata = s.hostWdata;
      e.gnt      = 1; e.ack = 1; e.stall = s.cpuEn;
      if (s.cpuEn) modelStalls++;
      if (burstRw) refMem[beat] = s.hostWdata;
      else begin
        pendRvalid = 1;
        pendRdata  = refMem[beat];
      end
      if (hostBeats.size() == 0) pendDone = 1;
    end else begin
      e.memEn = s.cpuEn; e.memRw = s.cpuRw; e.memAddr = s.cpuAddr; e.memWdata = s.cpuWdata;
      if (s.cpuEn && s.cpuRw) refMem[s.cpuAddr] = s.cpuWdata;
      if (s.hostReq && (!s.cpuEn || starve == STARVE_LIMIT)) begin
        n = int'(s.hostLen);
        if (n == 0) n = 1;
        if (n > MAX_BURST) n = MAX_BURST;
        for (int i = 0; i < n; i++) hostBeats.push_back(16'(int'(s.hostAddr) + i));
        burstRw = s.hostRw;
        starve  = 0;
      end else if (!s.hostReq) begin
        starve = 0;
      end else if (starve < STARVE_LIMIT) begin
        starve++;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input stimT s);
    @(negedge clk);
    s.cpuWdata  = 16'($urandom);
    s.hostWdata = 16'($urandom);
    rst_n          = s.rstN;
    bus.cpu_en     = s.cpuEn;
    bus.cpu_rw     = s.cpuRw;
    bus.cpu_addr   = s.cpuAddr;
    bus.cpu_wdata  = s.cpuWdata;
    bus.host_req   = s.hostReq;
    bus.host_rw    = s.hostRw;
    bus.host_addr  = s.hostAddr;
    bus.host_len   = s.hostLen;
    bus.host_wdata = s.hostWdata;
    runModel(s);
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input expT e);
    checkField("mem_en",      32'(bus.mem_en),      32'(e.memEn));
    checkField("mem_rw",      32'(bus.mem_rw),      32'(e.memRw));
    checkField("mem_addr",    32'(bus.mem_addr),    32'(e.memAddr));
    checkField("mem_wdata",   32'(bus.mem_wdata),   32'(e.memWdata));
    checkField("cpu_stall",   32'(bus.cpu_stall),   32'(e.stall));
    checkField("host_gnt",    32'(bus.host_gnt),    32'(e.gnt));
    checkField("host_ack",    32'(bus.host_ack),    32'(e.ack));
    checkField("host_rvalid", 32'(bus.host_rvalid), 32'(e.rvalid));
    checkField("host_rdata",  32'(bus.host_rdata),  32'(e.rdata));
    checkField("host_done",   32'(bus.host_done),   32'(e.done));
`ifdef DM_ARB_PERF_EN
    checkField("stall_cnt",   32'(stallCnt),        32'(e.stallCnt));
`endif
  endtask

  // Monitor: every cycle the DUT presents its port state, compare against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    stimT s;
    checks = 0; errors = 0; starve = 0; pendRvalid = 0; pendDone = 0;
    pendRdata = 0; modelStalls = 0; burstRw = 0;
    for (int i = 0; i < 65536; i++) begin
      dutMem[i] = 16'(i * 7 + 3);
      refMem[i] = 16'(i * 7 + 3);
    end
    rst_n = 1'b0;
    bus.cpu_en = 0; bus.cpu_rw = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.host_req = 0; bus.host_rw = 0; bus.host_addr = 0; bus.host_len = 0;
    bus.host_wdata = 0; bus.mem_rdata = 0;

    s = '0;
    repeat (2) applyStimulus(s);

    s.rstN = 1; s.cpuEn = 1; s.cpuAddr = 16'h0010;
    repeat (3) applyStimulus(s);

    s.cpuEn = 0; s.hostReq = 1; s.hostRw = 0; s.hostAddr = 16'h0100; s.hostLen = 4'd4;
    applyStimulus(s);
    s.hostReq = 0;
    repeat (6) applyStimulus(s);

    repeat (2) begin
      s.cpuEn = 1; s.cpuRw = 0; s.cpuAddr = 16'h0020;
      s.hostReq = 1; s.hostLen = 4'd2; s.hostAddr = 16'h0200;
      repeat (5) applyStimulus(s);
      s.hostReq = 0;
      repeat (4) applyStimulus(s);
    end

    s.cpuEn = 0; s.hostReq = 1; s.hostRw = 0; s.hostAddr = 16'h0300; s.hostLen = 4'd0;
    applyStimulus(s);
    s.hostReq = 0;
    repeat (3) applyStimulus(s);

    s.hostReq = 1; s.hostRw = 1; s.hostAddr = 16'h0400; s.hostLen = 4'd15;
    applyStimulus(s);
    s.hostReq = 0;
    repeat (10) applyStimulus(s);

    s.hostReq = 1; s.hostRw = 0; s.hostAddr = 16'hFFFE; s.hostLen = 4'd4;
    applyStimulus(s);
    s.hostReq = 0;
    repeat (6) applyStimulus(s);

    s.hostReq = 1; s.hostRw = 0; s.hostAddr = 16'h0500; s.hostLen = 4'd8;
    applyStimulus(s);
    s.hostReq = 0;
    applyStimulus(s);
    s.rstN = 0;
    applyStimulus(s);
    s.rstN = 1;
    repeat (4) applyStimulus(s);

    for (int c = 0; c < 800; c++) begin
      s.rstN     = ($urandom_range(0, 299) != 0);
      s.cpuEn    = ($urandom_range(0, 99) < 60);
      s.cpuRw    = 1'($urandom);
      s.cpuAddr  = 16'($urandom_range(0, 63));
      s.hostReq  = ($urandom_range(0, 99) < 35);
      s.hostRw   = 1'($urandom);
      s.hostAddr = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF))
                                                : 16'($urandom_range(0, 63));
      s.hostLen  = 4'($urandom);
      applyStimulus(s);
    end

    s = '0; s.rstN = 1;
    repeat (12) applyStimulus(s);
    @(negedge clk);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
